// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding req/ack reads
// and presents the fetched instruction to the IF/ID register (captured on negedge).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] next_PC,
  output logic [31:0] instruct,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic        valid,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_buf_data;
  logic [31:0] r_buf_pc;
  logic [31:0] r_next_pc;
  logic [31:0] r_instruct;
  logic        r_valid;

  logic [31:0] w_flush_pc;
  logic [31:0] w_req_inc;

  assign w_flush_pc = {flush_target[31:2], 2'b00};
  assign w_req_inc  = r_req_addr + 32'd4;

  // Memory handshake: imem_req is high in FETCH/DRAIN and imem_addr is the
  // registered r_req_addr; both stay put until the cycle in which imem_ack is
  // high, which completes the read in that same cycle (imem_rdata valid then).
  assign imem_req    = ((r_state == S_FETCH) || (r_state == S_DRAIN)) && !RST;
  assign imem_addr   = r_req_addr;
  assign next_PC     = r_next_pc;
  assign instruct    = r_instruct;
  assign Opcode      = r_instruct[31:26];
  assign Funct       = r_instruct[5:0];
  assign valid       = r_valid;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_buf_data <= 32'd0;
      r_buf_pc   <= 32'd0;
      r_next_pc  <= 32'd0;
      r_instruct <= 32'd0;
      r_valid    <= 1'b0;
    end else if (flush) begin
      r_pc       <= w_flush_pc;
      r_valid    <= 1'b0;
      r_instruct <= 32'd0;
      r_next_pc  <= 32'd0;
      r_buf_data <= 32'd0;
      r_buf_pc   <= 32'd0;
      case (r_state)
        S_FETCH: begin
          // An unacknowledged read cannot be withdrawn, so it is drained first.
          if (imem_ack) begin
            r_req_addr <= w_flush_pc;
            r_state    <= S_FETCH;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          r_req_addr <= w_flush_pc;
          r_state    <= S_FETCH;
        end
        default: r_state <= S_DRAIN;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            if (!stall) begin
              r_instruct <= imem_rdata;
              r_next_pc  <= w_req_inc;
              r_valid    <= 1'b1;
              r_pc       <= w_req_inc;
              r_req_addr <= w_req_inc;
            end else begin
              r_buf_data <= imem_rdata;
              r_buf_pc   <= w_req_inc;
              r_pc       <= w_req_inc;
              r_state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_instruct <= r_buf_data;
            r_next_pc  <= r_buf_pc;
            r_valid    <= 1'b1;
            r_req_addr <= r_pc;
            r_state    <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            r_req_addr <= r_pc;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-programmable memory responder, directed
// scenarios plus a random phase, with an expected-instruction queue.
module tb_if_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall;
  logic        flush;
  logic [31:0] flush_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] next_PC;
  logic [31:0] instruct;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic        valid;
  logic [1:0]  dbg_state;

  // Second instance starting at the top of the address space, zero-wait memory.
  logic        stall2;
  logic        flush2;
  logic [31:0] flush_target2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        imem_ack2;
  logic [31:0] next_PC2;
  logic [31:0] instruct2;
  logic [5:0]  Opcode2;
  logic [5:0]  Funct2;
  logic        valid2;
  logic [1:0]  dbg_state2;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat      = 0;
  int          wait_cnt = 0;
  bit          draining = 1'b0;
  logic [63:0] exp_q[$];
  logic [64:0] last_out = '0;

  always #5 CLK = ~CLK;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush), .flush_target(flush_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .next_PC(next_PC), .instruct(instruct), .Opcode(Opcode), .Funct(Funct),
    .valid(valid), .o_dbg_state(dbg_state)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RST(RST), .stall(stall2), .flush(flush2), .flush_target(flush_target2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_ack(imem_ack2),
    .next_PC(next_PC2), .instruct(instruct2), .Opcode(Opcode2), .Funct(Funct2),
    .valid(valid2), .o_dbg_state(dbg_state2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: answer memory, book-keep expectations, advance, then check outputs.
  task automatic step();
    logic        pending;
    logic [31:0] paddr;
    logic [63:0] e;
    logic [64:0] cur;
    if (imem_req && wait_cnt >= lat) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr + 32'h100;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    if (imem_req && !imem_ack) wait_cnt++;
    else wait_cnt = 0;
    imem_ack2   = 1'b1;
    imem_rdata2 = imem_addr2 + 32'h100;
    if (flush) begin
      exp_q.delete();
      draining = imem_req && !imem_ack;
    end else if (imem_ack) begin
      if (draining) draining = 1'b0;
      else exp_q.push_back({imem_addr + 32'd4, imem_addr + 32'h100});
    end
    pending = imem_req && !imem_ack && !RST;
    paddr   = imem_addr;
    @(posedge CLK);
    @(negedge CLK);
    if (pending) begin
      check("req_held", {63'd0, imem_req}, 64'd1);
      check("addr_held", {32'd0, imem_addr}, {32'd0, paddr});
    end
    cur = {valid, next_PC, instruct};
    if (!valid) begin
      check("bubble_instr", {32'd0, instruct}, 64'd0);
      check("bubble_npc", {32'd0, next_PC}, 64'd0);
    end else if (cur != last_out) begin
      check("sb_nonempty", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_npc", {32'd0, next_PC}, {32'd0, e[63:32]});
        check("sb_instr", {32'd0, instruct}, {32'd0, e[31:0]});
        check("sb_opcode", {58'd0, Opcode}, {58'd0, e[31:26]});
        check("sb_funct", {58'd0, Funct}, {58'd0, e[5:0]});
      end
    end
    last_out = cur;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; stall = 1'b0; flush = 1'b0; flush_target = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    stall2 = 1'b0; flush2 = 1'b0; flush_target2 = 32'd0;
    imem_ack2 = 1'b1; imem_rdata2 = 32'd0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_instr", {32'd0, instruct}, 64'd0);
    check("rst_npc", {32'd0, next_PC}, 64'd0);
    check("rst_addr", {32'd0, imem_addr}, 64'd0);
    check("rst_req2", {63'd0, imem_req2}, 64'd0);
    RST = 1'b0;
    #1;
    check("req_after_rst", {63'd0, imem_req}, 64'd1);
    check("addr2_reset_pc", {32'd0, imem_addr2}, 64'hFFFF_FFFC);

    // Zero-wait streaming from 0
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      check("zw_addr", {32'd0, imem_addr}, i * 4);
      step();
      check("zw_instr", {32'd0, instruct}, 32'h100 + i * 4);
      check("zw_npc", {32'd0, next_PC}, i * 4 + 4);
      check("zw_valid", {63'd0, valid}, 64'd1);
      if (i == 0) begin
        check("wrap_npc", {32'd0, next_PC2}, 64'd0);
        check("wrap_instr", {32'd0, instruct2}, 64'h0000_00FC);
        check("wrap_valid", {63'd0, valid2}, 64'd1);
        check("wrap_addr", {32'd0, imem_addr2}, 64'd0);
      end
      if (i == 1) check("wrap_npc2", {32'd0, next_PC2}, 64'd4);
    end

    // Two-cycle ack latency: request held three cycles per word
    lat = 2;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        check("lat_req", {63'd0, imem_req}, 64'd1);
        check("lat_addr", {32'd0, imem_addr}, 16 + r * 4);
        step();
      end
      check("lat_instr", {32'd0, instruct}, 32'h110 + r * 4);
    end

    // Stall in the ack cycle, held three cycles
    lat = 0;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_req", {63'd0, imem_req}, 64'd0);
      check("hold_state", {62'd0, dbg_state}, 64'd1);
      check("hold_instr", {32'd0, instruct}, 64'h114);
    end
    stall = 1'b0;
    step();
    check("rel_instr", {32'd0, instruct}, 64'h118);
    check("rel_npc", {32'd0, next_PC}, 64'd28);
    check("rel_addr", {32'd0, imem_addr}, 64'd28);
    step();
    check("rel_next", {32'd0, instruct}, 64'h11C);

    // Flush with an outstanding unacknowledged read at 32
    lat = 2;
    step();
    flush = 1'b1; flush_target = 32'h0000_0040;
    step();
    flush = 1'b0;
    check("fl_valid", {63'd0, valid}, 64'd0);
    check("fl_drain_addr", {32'd0, imem_addr}, 64'd32);
    check("fl_drain_state", {62'd0, dbg_state}, 64'd2);
    step();
    check("fl_new_addr", {32'd0, imem_addr}, 64'h40);
    check("fl_still_bubble", {63'd0, valid}, 64'd0);

    // Stall while the bubble is presented, then release
    lat = 0;
    stall = 1'b1;
    step();
    check("bub_stall_valid", {63'd0, valid}, 64'd0);
    stall = 1'b0;
    step();
    check("bub_rel_instr", {32'd0, instruct}, 64'h140);
    step();

    // Flush and stall together while in HOLD, unaligned target
    stall = 1'b1;
    step();
    check("hf_state", {62'd0, dbg_state}, 64'd1);
    flush = 1'b1; flush_target = 32'h0000_0203;
    step();
    flush = 1'b0; stall = 1'b0;
    check("hf_valid", {63'd0, valid}, 64'd0);
    check("hf_addr", {32'd0, imem_addr}, 64'h200);
    step();
    check("hf_instr", {32'd0, instruct}, 64'h300);

    // Flush coinciding with an ack: data discarded, immediate redirect
    flush = 1'b1; flush_target = 32'h0000_0080;
    step();
    flush = 1'b0;
    check("fa_addr", {32'd0, imem_addr}, 64'h80);
    check("fa_valid", {63'd0, valid}, 64'd0);
    step();
    check("fa_instr", {32'd0, instruct}, 64'h180);

    // Random stall / latency / flush traffic
    for (int c = 0; c < 80; c++) begin
      if (wait_cnt == 0) lat = $urandom_range(0, 2);
      stall = ($urandom_range(0, 3) == 0);
      flush = !draining && ($urandom_range(0, 9) == 0);
      flush_target = $urandom;
      step();
    end
    flush = 1'b0; stall = 1'b0; lat = 0;
    repeat (6) step();
    check("sb_drained", {32'd0, exp_q.size()}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
